// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: sequences weight/input ROM reads and computes one fully-connected layer,
// streaming one saturated (optionally ReLU'd) fixed-point result per neuron over valid/ready.
module neuron_mac_seq #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int N_INPUTS   = 784,
  parameter int N_NEURONS  = 10,
  parameter int BIAS_BASE  = N_NEURONS * N_INPUTS,
  parameter int ACC_WIDTH  = 42,
  parameter int RELU       = 1,
  localparam int IW        = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_q,
  output logic [ADDR_WIDTH-1:0] x_addr,
  input  logic [DATA_WIDTH-1:0] x_q,
  output logic                  y_valid,
  input  logic                  y_ready,
  output logic [DATA_WIDTH-1:0] y_data,
  output logic [IW-1:0]         y_index
);
  typedef enum logic [2:0] {IDLE, FETCH, BIAS, FIN, OUT} state_t;
  localparam logic signed [ACC_WIDTH-1:0] SMAX = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SMIN = ~SMAX;
  state_t                         r_state;
  logic [ADDR_WIDTH-1:0]          r_wp;
  logic [ADDR_WIDTH-1:0]          r_k;
  logic [IW-1:0]                  r_j;
  logic                           r_dv;
  logic signed [ACC_WIDTH-1:0]    r_acc;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]    w_prod_x;
  logic signed [ACC_WIDTH-1:0]    w_bias;
  logic signed [ACC_WIDTH-1:0]    w_sum;
  logic signed [ACC_WIDTH-1:0]    w_shr;
  logic [DATA_WIDTH-1:0]          w_res;
  assign w_prod   = $signed(w_q) * $signed(x_q);
  assign w_prod_x = {{(ACC_WIDTH-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};
  // bias is aligned to the product's 2*FRAC_BITS scale before the final shift
  assign w_bias   = {{(ACC_WIDTH-DATA_WIDTH){w_q[DATA_WIDTH-1]}}, w_q} <<< FRAC_BITS;
  assign w_sum    = r_acc + w_bias;
  assign w_shr    = w_sum >>> FRAC_BITS;
  assign w_res    = (RELU != 0 && w_shr[ACC_WIDTH-1]) ? '0 :
                    (w_shr > SMAX) ? SMAX[DATA_WIDTH-1:0] :
                    (w_shr < SMIN) ? SMIN[DATA_WIDTH-1:0] : w_shr[DATA_WIDTH-1:0];
  assign busy   = r_state != IDLE;
  assign w_addr = (r_state == FETCH) ? r_wp :
                  (r_state == IDLE) ? '0 : ADDR_WIDTH'(BIAS_BASE) + ADDR_WIDTH'(r_j);
  assign x_addr = (r_state == FETCH) ? r_k : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_wp    <= '0;
      r_k     <= '0;
      r_j     <= '0;
      r_dv    <= 1'b0;
      r_acc   <= '0;
      done    <= 1'b0;
      y_valid <= 1'b0;
      y_data  <= '0;
      y_index <= '0;
    end else begin
      r_dv <= r_state == FETCH;
      done <= 1'b0;
      if (r_dv) r_acc <= r_acc + w_prod_x;
      case (r_state)
        IDLE: if (start) begin
          r_j     <= '0;
          r_k     <= '0;
          r_wp    <= '0;
          r_acc   <= '0;
          r_state <= FETCH;
        end
        FETCH: begin
          r_wp <= r_wp + 1'b1;
          r_k  <= r_k + 1'b1;
          if (r_k == ADDR_WIDTH'(N_INPUTS - 1)) r_state <= BIAS;
        end
        BIAS: r_state <= FIN;
        FIN: begin
          y_data  <= w_res;
          y_index <= r_j;
          y_valid <= 1'b1;
          r_state <= OUT;
        end
        OUT: if (y_ready) begin
          y_valid <= 1'b0;
          if (r_j == IW'(N_NEURONS - 1)) begin
            done    <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_j     <= r_j + 1'b1;
            r_k     <= '0;
            r_acc   <= '0;
            r_state <= FETCH;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_mac_seq.sv
// tb_neuron_mac_seq: two small instances (RELU on/off) fed from shared ROM images;
// expected results are queued per layer and popped by a monitor on each handshake.
module tb_neuron_mac_seq;
  localparam int NI = 4;
  localparam int NN = 2;
  localparam int BB = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic y_ready = 1'b1;
  logic busy1, done1, yv1, yi1, busy0, done0, yv0, yi0;
  logic [15:0] wa1, xa1, wq1, xq1, yd1, wa0, xa0, wq0, xq0, yd0;
  logic [15:0] wrom [16];
  logic [15:0] xrom [4];
  logic [16:0] q1 [$];
  logic [16:0] q0 [$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  neuron_mac_seq #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .FRAC_BITS(8), .N_INPUTS(NI), .N_NEURONS(NN),
    .BIAS_BASE(BB), .ACC_WIDTH(36), .RELU(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy1), .done(done1),
    .w_addr(wa1), .w_q(wq1), .x_addr(xa1), .x_q(xq1),
    .y_valid(yv1), .y_ready(y_ready), .y_data(yd1), .y_index(yi1));
  neuron_mac_seq #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .FRAC_BITS(8), .N_INPUTS(NI), .N_NEURONS(NN),
    .BIAS_BASE(BB), .ACC_WIDTH(36), .RELU(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy0), .done(done0),
    .w_addr(wa0), .w_q(wq0), .x_addr(xa0), .x_q(xq0),
    .y_valid(yv0), .y_ready(y_ready), .y_data(yd0), .y_index(yi0));
  always @(posedge clk) begin
    wq1 <= wrom[wa1[3:0]];
    xq1 <= xrom[xa1[1:0]];
    wq0 <= wrom[wa0[3:0]];
    xq0 <= xrom[xa0[1:0]];
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  // monitor: inputs change on the falling edge, so sample just after it
  always begin
    logic [16:0] e;
    @(negedge clk);
    #1;
    if (rst_n && yv1 && y_ready) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL y1_unexpected actual=%0h required=none", {yi1, yd1});
      end else begin
        e = q1.pop_front();
        chk("y1", {15'b0, yi1, yd1}, {15'b0, e});
      end
    end
    if (rst_n && yv0 && y_ready) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL y0_unexpected actual=%0h required=none", {yi0, yd0});
      end else begin
        e = q0.pop_front();
        chk("y0", {15'b0, yi0, yd0}, {15'b0, e});
      end
    end
  end
  task automatic setw(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] b0,
                      input logic [15:0] b1, input logic [15:0] xv);
    for (int i = 0; i < 16; i++) wrom[i] = 16'h0;
    for (int i = 0; i < NI; i++) begin
      wrom[i]      = w0;
      wrom[NI + i] = w1;
      xrom[i]      = xv;
    end
    wrom[BB]     = b0;
    wrom[BB + 1] = b1;
  endtask
  task automatic layer(input logic [15:0] a1, input logic [15:0] b1, input logic [15:0] a0,
                       input logic [15:0] b0, input int ncyc, input bit achk, input bit stall,
                       input bit poke);
    int n;
    int wexp [15] = '{-1, 0, 1, 2, 3, BB, -1, -1, 4, 5, 6, 7, BB + 1, -1, -1};
    int xexp [15] = '{-1, 0, 1, 2, 3, -1, -1, -1, 0, 1, 2, 3, -1, -1, -1};
    q1.push_back({1'b0, a1});
    q1.push_back({1'b1, b1});
    q0.push_back({1'b0, a0});
    q0.push_back({1'b1, b0});
    start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start = poke && n == 2;
      if (achk && n < 15 && wexp[n] >= 0) chk("w_addr", wa1, wexp[n]);
      if (achk && n < 15 && xexp[n] >= 0) chk("x_addr", xa1, xexp[n]);
      if (stall) begin
        if (n == 6) y_ready = 1'b0;
        if (n >= 7 && n <= 12) begin
          chk("bp_valid", yv1, 1);
          chk("bp_data", yd1, a1);
          chk("bp_index", yi1, 0);
          chk("bp_waddr", wa1, BB);
        end
        if (n == 12) y_ready = 1'b1;
        if (n == 13) chk("bp_resume", wa1, 4);
      end
    end while (!done1 && n < 200);
    chk("layer_cycles", n, ncyc);
    chk("done0", done0, 1);
    chk("queue_drained", q1.size() + q0.size(), 0);
    @(negedge clk);
    chk("done_pulse", done1, 0);
    chk("idle_waddr", wa1, 0);
    chk("idle_xaddr", xa1, 0);
    chk("idle_busy", busy1, 0);
  endtask
  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_valid", yv1, 0);
    chk("rst_data", yd1, 0);
    chk("rst_index", yi1, 0);
    chk("rst_waddr", wa1, 0);
    chk("rst_xaddr", xa1, 0);
    rst_n = 1'b1;
    @(negedge clk);
    setw(16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0100);
    layer(16'h0400, 16'h0400, 16'h0400, 16'h0400, 1 + NN * (NI + 3), 1, 0, 0);
    setw(16'hFF00, 16'hFF00, 16'h0000, 16'h0000, 16'h0100);
    layer(16'h0000, 16'h0000, 16'hFC00, 16'hFC00, 15, 0, 0, 0);
    setw(16'h0100, 16'h0200, 16'h0080, 16'h0000, 16'h0100);
    layer(16'h0480, 16'h0800, 16'h0480, 16'h0800, 15, 0, 0, 0);
    setw(16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF);
    layer(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 15, 0, 0, 0);
    setw(16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h7FFF);
    layer(16'h0000, 16'h0000, 16'h8000, 16'h8000, 15, 0, 0, 0);
    // -192/256 must round toward -inf to -1, +192/256 truncates to 0
    setw(16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h0030);
    layer(16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 15, 0, 0, 0);
    setw(16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0100);
    layer(16'h0400, 16'h0400, 16'h0400, 16'h0400, 20, 0, 1, 0);
    layer(16'h0400, 16'h0400, 16'h0400, 16'h0400, 15, 0, 0, 1);
    repeat (3) @(negedge clk);
    chk("start_ignored_idle", busy1, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy1, 0);
    chk("abort_done", done1, 0);
    chk("abort_valid", yv1, 0);
    chk("abort_data", yd1, 0);
    chk("abort_waddr", wa1, 0);
    chk("abort_xaddr", xa1, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done1 || yv1 || busy1) seen = 1'b1;
    end
    chk("abort_quiet", seen, 0);
    setw(16'h0100, 16'h0200, 16'h0080, 16'h0000, 16'h0100);
    layer(16'h0480, 16'h0800, 16'h0480, 16'h0800, 15, 1, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
